posit_encoder_pipe_8bit: RTL and testbench

POSIT_ENCODER_PIPE_8BIT -- requirements
Module: posit_encoder_pipe_8bit

---
 rtl/posit_encoder_pipe_8bit_if.sv | 18 +
 rtl/posit_encoder_pipe_8bit.sv | 72 +++++++
 tb/tb_posit_encoder_pipe_8bit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/posit_encoder_pipe_8bit_if.sv
// posit_encoder_pipe_8bit_if: valid/ready handshake bundle between the posit encoder and its neighbours
interface posit_encoder_pipe_8bit_if;
  logic in_valid;
  logic in_ready;
  logic [13:0] in_eposit;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_posit;
  logic out_inexact;
  modport master (
    output in_valid, in_eposit, out_ready,
    input in_ready, out_valid, out_posit, out_inexact
  );
  modport slave (
    input in_valid, in_eposit, out_ready,
    output in_ready, out_valid, out_posit, out_inexact
  );
endinterface

// File: rtl/posit_encoder_pipe_8bit.sv
// posit_encoder_pipe_8bit: two-stage encoder from extended posit to 8-bit es=0 posit with RNE and saturation
module posit_encoder_pipe_8bit (
  input  logic clk,
  input  logic rst_n,
  posit_encoder_pipe_8bit_if.slave bus,
  input  logic cnt_clr,
  output logic [7:0] inexact_cnt
);
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic s1_spec, spec;
  logic [9:0] s1_body, body;
  logic [3:0] e, r;
  logic kpos, rb, sgn, st1;
  logic [22:0] t;
  logic [7:0] u;
  logic [7:0] kept, res;
  logic [8:0] sum;
  logic rnd, st, clamp, inexact;
  assign s2_adv = ~s2_valid | bus.out_ready;
  assign s1_adv = s2_adv | ~s1_valid;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  // Regime run of length r sits above a terminator at t[7]; shifting by r aligns
  // the first seven bits after the sign, the round bit at u[0], and the rest as sticky.
  always_comb begin
    e = bus.in_eposit[10:7];
    sgn = bus.in_eposit[11];
    kpos = e >= 4'd7;
    r = kpos ? e - 4'd6 : 4'd7 - e;
    rb = kpos ^ sgn;
    t = {{15{rb}}, ~rb, bus.in_eposit[6:0]};
    u = 8'(t >> r);
    st1 = |(t & ~(23'h7fffff << r));
    spec = bus.in_eposit[13] | bus.in_eposit[12];
    body = bus.in_eposit[13] ? 10'h200 : bus.in_eposit[12] ? 10'h000 : {sgn, u, st1};
  end
  always_comb begin
    kept = s1_body[9:2];
    rnd = s1_body[1];
    st = s1_body[0];
    sum = {1'b0, kept} + {8'd0, rnd & (st | kept[0])};
    res = s1_spec ? kept
        : ~kept[7] ? (sum[7] ? 8'h7f : sum[7:0] == 8'h00 ? 8'h01 : sum[7:0])
        : (sum[8] ? 8'hff : sum[7:0] == 8'h80 ? 8'h81 : sum[7:0]);
    clamp = res != sum[7:0];
    inexact = ~s1_spec & (rnd | st | clamp);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_body <= '0;
      s1_spec <= 1'b0;
      s2_valid <= 1'b0;
      bus.out_posit <= '0;
      bus.out_inexact <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= bus.in_valid;
      if (s1_adv && bus.in_valid) begin
        s1_body <= body;
        s1_spec <= spec;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        bus.out_posit <= res;
        bus.out_inexact <= inexact;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inexact_cnt <= '0;
    else if (cnt_clr) inexact_cnt <= '0;
    else if (s2_valid && bus.out_ready && bus.out_inexact && !(&inexact_cnt)) inexact_cnt <= inexact_cnt + 8'd1;
endmodule

// File: tb/tb_posit_encoder_pipe_8bit.sv
// tb_posit_encoder_pipe_8bit: directed vector table plus backpressure, counter and reset sequences
module tb_posit_encoder_pipe_8bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;
  logic [7:0] inexact_cnt;
  int checks = 0;
  int errors = 0;
  int n_inx;
  int sent, got, stall;
  bit seen, low, held, ix, ox;
  logic [7:0] hv;
  posit_encoder_pipe_8bit_if bus();
  posit_encoder_pipe_8bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .cnt_clr(cnt_clr),
    .inexact_cnt(inexact_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [13:0] ep;
    logic [7:0] posit;
    logic inexact;
  } vec_t;
  vec_t tbl[18];
  function automatic logic [13:0] ep(input logic inf, input logic zer, input logic sgn,
                                     input logic [3:0] e, input logic [6:0] f);
    return {inf, zer, sgn, e, f};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_one(input logic [13:0] v);
    bus.in_valid = 1'b1;
    bus.in_eposit = v;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{ep(0,0,0,4'd7, 7'h00), 8'h40, 1'b0};
    tbl[1]  = '{ep(0,0,0,4'd7, 7'h40), 8'h50, 1'b0};
    tbl[2]  = '{ep(0,0,0,4'd13,7'h00), 8'h7f, 1'b0};
    tbl[3]  = '{ep(0,0,0,4'd1, 7'h00), 8'h01, 1'b0};
    tbl[4]  = '{ep(0,0,1,4'd6, 7'h00), 8'hc0, 1'b0};
    tbl[5]  = '{ep(0,0,0,4'd7, 7'h02), 8'h40, 1'b1};
    tbl[6]  = '{ep(0,0,0,4'd7, 7'h06), 8'h42, 1'b1};
    tbl[7]  = '{ep(0,0,0,4'd7, 7'h07), 8'h42, 1'b1};
    tbl[8]  = '{ep(1,1,0,4'd7, 7'h00), 8'h80, 1'b0};
    tbl[9]  = '{ep(0,1,0,4'd7, 7'h55), 8'h00, 1'b0};
    tbl[10] = '{ep(0,0,0,4'd15,7'h00), 8'h7f, 1'b1};
    tbl[11] = '{ep(0,0,0,4'd0, 7'h00), 8'h01, 1'b1};
    tbl[12] = '{ep(0,0,1,4'd0, 7'h40), 8'hff, 1'b1};
    tbl[13] = '{ep(0,0,1,4'd14,7'h00), 8'h81, 1'b1};
    tbl[14] = '{ep(0,0,1,4'd13,7'h00), 8'h81, 1'b1};
    tbl[15] = '{ep(0,0,0,4'd8, 7'h7f), 8'h70, 1'b1};
    tbl[16] = '{ep(0,0,0,4'd13,7'h7f), 8'h7f, 1'b1};
    tbl[17] = '{ep(0,0,1,4'd7, 7'h00), 8'ha0, 1'b0};
    bus.in_valid = 1'b0;
    bus.in_eposit = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_posit", bus.out_posit, 0);
    chk("rst_out_inexact", bus.out_inexact, 0);
    chk("rst_cnt", inexact_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_inx = 0;
    for (int i = 0; i < 18; i++) begin
      bus.in_valid = 1'b1;
      bus.in_eposit = tbl[i].ep;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk($sformatf("lat_%0d", i), bus.out_valid, 0);
      @(posedge clk);
      #1;
      chk($sformatf("valid_%0d", i), bus.out_valid, 1);
      chk($sformatf("posit_%0d", i), bus.out_posit, tbl[i].posit);
      chk($sformatf("inexact_%0d", i), bus.out_inexact, tbl[i].inexact);
      if (tbl[i].inexact) n_inx++;
    end
    @(posedge clk);
    #1 chk("table_cnt", inexact_cnt, n_inx);
    sent = 0; got = 0; stall = 0; seen = 0; low = 0; held = 0;
    bus.in_valid = 1'b1;
    bus.in_eposit = tbl[0].ep;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      ix = bus.in_valid & bus.in_ready;
      ox = bus.out_valid & bus.out_ready;
      if (held) chk("bp_hold", bus.out_posit, hv);
      held = bus.out_valid & ~bus.out_ready;
      hv = bus.out_posit;
      if (ox) begin
        chk($sformatf("bp_data_%0d", got), bus.out_posit, tbl[got].posit);
        got++;
      end
      if (bus.in_valid && !bus.in_ready) low = 1'b1;
      @(posedge clk);
      #1;
      if (ix) begin
        sent++;
        bus.in_valid = sent < 5;
        bus.in_eposit = tbl[sent < 5 ? sent : 0].ep;
      end
      if (!seen && bus.out_valid) begin
        seen = 1'b1;
        stall = 3;
      end
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end else bus.out_ready = 1'b1;
    end
    chk("bp_got", got, 5);
    chk("bp_sent", sent, 5);
    chk("bp_in_ready_low", low, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 chk("bp_no_extra", bus.out_valid, 0);
    end
    bus.in_valid = 1'b1;
    bus.in_eposit = ep(0,0,0,4'd15,7'h00);
    repeat (260) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cnt_sat", inexact_cnt, 255);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("cnt_clr", inexact_cnt, 0);
    send_one(ep(0,0,0,4'd15,7'h00));
    @(posedge clk);
    #1 chk("cnt_one", inexact_cnt, 1);
    send_one(ep(0,0,0,4'd15,7'h00));
    chk("clr_pri_valid", bus.out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("cnt_clr_pri", inexact_cnt, 0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_eposit = tbl[1].ep;
    @(posedge clk);
    #1 bus.in_eposit = tbl[4].ep;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("flight_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_posit", bus.out_posit, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1 chk("no_stale", bus.out_valid, 0);
    end
    chk("post_rst_cnt", inexact_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
